// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage types and constants.
// Holds address/instruction widths, reset PC and the prefetch entry struct.
package cpu_fetch_pkg;

    localparam int ADDR_W      = 8;
    localparam int INSTR_W     = 16;
    localparam int INSTR_BYTES = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry prefetch FIFO of fetch_entry_t with push/pop/flush.
// Ports: clk, rst_n (async low), push, pop, flush, din, head, count.
module fetch_buf2
    import cpu_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t e0;
    fetch_entry_t e1;
    logic [1:0]   cnt;
    logic         pop_ok;
    logic         push_ok;

    // Guard against popping empty or pushing into a full buffer.
    assign pop_ok  = pop && (cnt != 2'd0);
    assign push_ok = push && ((cnt != 2'd2) || pop_ok);

    assign head  = e0;
    assign count = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= din;
                    else             e1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    // Last entry leaving: head keeps its stale value.
                    if (cnt == 2'd2) e0 <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, memory address drive, 2-deep prefetch.
// Ports: CLK, RESET_N, IADDR/IDATA (imem), STALL_FETCH, REDIRECT(_PC), INSTR* to decode.
module instr_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int INSTR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic               CLK,
    input  logic               RESET_N,
    output logic [ADDR_W-1:0]  IADDR,
    input  logic [INSTR_W-1:0] IDATA,
    input  logic               STALL_FETCH,
    input  logic               REDIRECT,
    input  logic [ADDR_W-1:0]  REDIRECT_PC,
    output logic [INSTR_W-1:0] INSTR,
    output logic [ADDR_W-1:0]  INSTR_PC,
    output logic               INSTR_VALID,
    input  logic               INSTR_READY
);

    import cpu_fetch_pkg::*;

    logic [ADDR_W-1:0] pc_q;
    logic [1:0]        count;
    logic              pop;
    logic              push;
    fetch_entry_t      din;
    fetch_entry_t      head;

    assign IADDR       = pc_q;
    assign INSTR_VALID = (count != 2'd0);
    assign INSTR       = head.instr;
    assign INSTR_PC    = head.pc;

    assign pop  = INSTR_VALID && INSTR_READY;
    assign push = !REDIRECT && !STALL_FETCH
               && ((count != 2'd2) || pop);

    assign din.pc    = pc_q;
    assign din.instr = IDATA;

    fetch_buf2 u_buf (
        .clk   (CLK),
        .rst_n (RESET_N),
        .push  (push),
        .pop   (pop),
        .flush (REDIRECT),
        .din   (din),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q <= RESET_PC;
        end else if (REDIRECT) begin
            // Targets are halfword aligned; force bit 0 low.
            pc_q <= REDIRECT_PC & ~ADDR_W'(1);
        end else if (push) begin
            pc_q <= pc_q + ADDR_W'(INSTR_BYTES);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Combinational imem model; checks sampled on the falling edge.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  IADDR;
    logic [15:0] IDATA;
    logic        STALL_FETCH;
    logic        REDIRECT;
    logic [7:0]  REDIRECT_PC;
    logic [15:0] INSTR;
    logic [7:0]  INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mem [128];

    always #5 CLK = ~CLK;

    assign IDATA = mem[IADDR[7:1]];

    instr_fetch_unit dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IADDR       (IADDR),
        .IDATA       (IDATA),
        .STALL_FETCH (STALL_FETCH),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .INSTR       (INSTR),
        .INSTR_PC    (INSTR_PC),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk_out(input string tag,
                           input logic        v,
                           input logic [15:0] i,
                           input logic [7:0]  p,
                           input logic [7:0]  a);
        check({tag, ".valid"}, {31'd0, INSTR_VALID}, {31'd0, v});
        if (v) begin
            check({tag, ".instr"}, {16'd0, INSTR}, {16'd0, i});
            check({tag, ".pc"}, {24'd0, INSTR_PC}, {24'd0, p});
        end
        check({tag, ".iaddr"}, {24'd0, IADDR}, {24'd0, a});
    endtask

    initial begin
        for (int k = 0; k < 128; k++) mem[k] = 16'h0000;
        mem[0]  = 16'hF491;
        mem[1]  = 16'hF249;
        mem[2]  = 16'h54BF;
        mem[14] = 16'hF6D9;

        RESET_N     = 1'b0;
        STALL_FETCH = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 8'h00;
        INSTR_READY = 1'b1;

        #3;
        check("rst.valid", {31'd0, INSTR_VALID}, 32'd0);
        check("rst.instr", {16'd0, INSTR}, 32'd0);
        check("rst.pc", {24'd0, INSTR_PC}, 32'd0);
        check("rst.iaddr", {24'd0, IADDR}, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // 1: streaming after reset
        chk_out("t1.0", 1'b0, 16'h0, 8'h00, 8'h00);
        cyc(); chk_out("t1.1", 1'b1, 16'hF491, 8'h00, 8'h02);
        cyc(); chk_out("t1.2", 1'b1, 16'hF249, 8'h02, 8'h04);
        cyc(); chk_out("t1.3", 1'b1, 16'h54BF, 8'h04, 8'h06);

        // 2: decode back-pressure fills buffer
        RESET_N     = 1'b0;
        INSTR_READY = 1'b0;
        #1;
        chk_out("t2.rst", 1'b0, 16'h0, 8'h00, 8'h00);
        #1 RESET_N = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        chk_out("t2.full", 1'b1, 16'hF491, 8'h00, 8'h04);
        INSTR_READY = 1'b1;
        cyc(); chk_out("t2.p1", 1'b1, 16'hF249, 8'h02, 8'h06);
        cyc(); chk_out("t2.p2", 1'b1, 16'h54BF, 8'h04, 8'h08);

        // 3: redirect while head handshaked
        REDIRECT    = 1'b1;
        REDIRECT_PC = 8'h1D;
        cyc();
        REDIRECT = 1'b0;
        chk_out("t3.bub", 1'b0, 16'h0, 8'h00, 8'h1C);
        cyc(); chk_out("t3.tgt", 1'b1, 16'hF6D9, 8'h1C, 8'h1E);

        // 4: redirect to 0xFE, PC wraps
        REDIRECT    = 1'b1;
        REDIRECT_PC = 8'hFE;
        cyc();
        REDIRECT = 1'b0;
        chk_out("t4.bub", 1'b0, 16'h0, 8'h00, 8'hFE);
        cyc(); chk_out("t4.fe", 1'b1, 16'h0000, 8'hFE, 8'h00);
        cyc(); chk_out("t4.wrap", 1'b1, 16'hF491, 8'h00, 8'h02);

        // 5: async reset with full buffer
        INSTR_READY = 1'b0;
        cyc();
        cyc();
        chk_out("t5.full", 1'b1, 16'hF491, 8'h00, 8'h04);
        #2 RESET_N = 1'b0;
        #1;
        chk_out("t5.rst", 1'b0, 16'h0, 8'h00, 8'h00);
        #1 RESET_N = 1'b1;
        INSTR_READY = 1'b1;
        cyc(); chk_out("t5.1", 1'b1, 16'hF491, 8'h00, 8'h02);
        cyc(); chk_out("t5.2", 1'b1, 16'hF249, 8'h02, 8'h04);
        cyc(); chk_out("t5.3", 1'b1, 16'h54BF, 8'h04, 8'h06);

        // 6: stall drains buffer, redirect during stall
        INSTR_READY = 1'b0;
        cyc();
        cyc();
        chk_out("t6.full", 1'b1, 16'h54BF, 8'h04, 8'h08);
        STALL_FETCH = 1'b1;
        INSTR_READY = 1'b1;
        cyc(); chk_out("t6.d1", 1'b1, 16'h0000, 8'h06, 8'h08);
        cyc(); chk_out("t6.d2", 1'b0, 16'h0, 8'h00, 8'h08);
        REDIRECT    = 1'b1;
        REDIRECT_PC = 8'h1C;
        cyc();
        REDIRECT = 1'b0;
        chk_out("t6.rd", 1'b0, 16'h0, 8'h00, 8'h1C);
        cyc(); chk_out("t6.hold", 1'b0, 16'h0, 8'h00, 8'h1C);
        STALL_FETCH = 1'b0;
        cyc(); chk_out("t6.go", 1'b1, 16'hF6D9, 8'h1C, 8'h1E);

        // back-to-back redirects: last wins
        REDIRECT    = 1'b1;
        REDIRECT_PC = 8'h05;
        cyc();
        REDIRECT_PC = 8'h01;
        cyc();
        REDIRECT = 1'b0;
        chk_out("b2b.bub", 1'b0, 16'h0, 8'h00, 8'h00);
        cyc(); chk_out("b2b.tgt", 1'b1, 16'hF491, 8'h00, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface.
- Drives the byte address into the 16-bit instruction memory, which is read combinationally (word index = ADDR[7:1], same-cycle data).
- Captures each returned word with its PC into a 2-entry prefetch buffer.
- Presents instructions to decode with a valid/ready handshake; supports branch redirect and fetch stall.

Parameters:
- ADDR_W, 8, byte-address / PC width
- INSTR_W, 16, instruction width
- RESET_PC, 8'h00, PC loaded on reset (even)

Ports:
- CLK  input  1  system clock, rising edge
- RESET_N  input  1  asynchronous, active-low reset
- IADDR  output  ADDR_W  byte address to instruction memory ADDR; always even
- IDATA  input  INSTR_W  instruction memory Q, valid same cycle as IADDR
- STALL_FETCH  input  1  when 1, no new word is captured and the PC holds
- REDIRECT  input  1  branch/jump taken; flush and reload PC
- REDIRECT_PC  input  ADDR_W  redirect target; bit 0 ignored
- INSTR  output  INSTR_W  head-of-buffer instruction
- INSTR_PC  output  ADDR_W  PC of INSTR
- INSTR_VALID  output  1  buffer non-empty
- INSTR_READY  input  1  decode accepts INSTR this cycle

Behaviour:
- Reset (RESET_N=0, asynchronous, takes effect immediately):
  - PC=RESET_PC, so IADDR=RESET_PC.
  - Buffer count=0; INSTR_VALID=0; INSTR=0; INSTR_PC=0.
  - Applies mid-operation: all buffered entries are discarded.
- IADDR = PC register, combinational from the register only; it never depends on IDATA.
- Conditions evaluated each cycle:
  - pop = INSTR_VALID & INSTR_READY.
  - push = !REDIRECT & !STALL_FETCH & (count<2 | pop).
- On a rising edge with push:
  - {PC, IDATA} is written at the buffer tail.
  - PC <= PC+2, modulo 2^ADDR_W (0xFE wraps to 0x00).
- Pop removes the head entry. Push and pop in the same cycle is legal: count is unchanged, order is preserved.
- Full (count=2) with no pop: no push, PC holds, IADDR is stable.
- Empty: INSTR_VALID=0. INSTR/INSTR_PC hold their last values, and decode must ignore them.
- Latency: a word fetched at edge N is visible on INSTR with INSTR_VALID=1 after edge N when the buffer was empty (1 cycle from IADDR presentation). Steady-state throughput is 1 instruction/cycle.
- Redirect:
  - At the edge: count <= 0 and PC <= {REDIRECT_PC[ADDR_W-1:1],1'b0}. No push occurs in that cycle.
  - A head entry handshaked in the same cycle (pop=1) counts as consumed; this is the branch itself. All other entries are dropped.
  - INSTR_VALID=0 for exactly one cycle after the redirect edge, then the target instruction appears (redirect-to-valid = 2 edges).
- Redirect has priority over STALL_FETCH.
- Redirect while STALL_FETCH=1: PC is still reloaded; fetch resumes from the target when the stall drops.
- Back-to-back redirects: the last one wins. Each flushes again.
- STALL_FETCH=1 while decode keeps popping: the buffer drains to empty, INSTR_VALID falls, IADDR holds.
- No combinational path from INSTR_READY to IADDR.

Decomposition:
- Shared package cpu_fetch_pkg:
  - constants ADDR_W=8, INSTR_W=16, RESET_PC=8'h00, INSTR_BYTES=2.
  - typedef fetch_entry_t = {pc[ADDR_W-1:0], instr[INSTR_W-1:0]}.
- Sub-module fetch_buf2: 2-entry synchronous FIFO of fetch_entry_t with push/pop/flush, count output, and async active-low reset.
- The top level holds the PC register and the push/pop/redirect control.

Test Plan:
- Memory model: a combinational model loaded with the current program (mem[0]=16'hF491, mem[1]=16'hF249, mem[2]=16'h54BF, mem[14]=16'hF6D9, all others 0).
1. Release reset with INSTR_READY=1 held → IADDR steps 0x00,0x02,0x04 on successive edges. After the first edge: INSTR=F491, PC 0x00. Next: F249, PC 0x02. Next: 54BF, PC 0x04. INSTR_VALID stays 1 throughout.
2. INSTR_READY=0 for 5 cycles after reset → buffer fills to 2, IADDR frozen at 0x04, INSTR=F491 held. Raise READY → F491, F249, 54BF in order with no gaps or duplicates.
3. Pulse REDIRECT with REDIRECT_PC=0x1D while the head is handshaked → next cycle INSTR_VALID=0 and IADDR=0x1C. Following cycle INSTR=F6D9, INSTR_PC=0x1C.
4. Redirect to 0xFE → INSTR_PC sequence 0xFE, then 0x00 (F491). Wrap-around is correct.
5. Assert RESET_N=0 between clock edges with the buffer full → INSTR_VALID=0 and IADDR=0x00 before the next edge. After release, the scenario 1 sequence repeats.
6. STALL_FETCH=1 with READY=1 and the buffer full → 2 more instructions pop, then INSTR_VALID=0 and IADDR held. Assert REDIRECT during the stall → PC reloads, no capture until STALL_FETCH=0.
